edulent_out_uart: RTL and testbench

EDULENT_OUT_UART -- requirements
Module: edulent_out_uart

---
 rtl/edulent_pkg.sv | 11 +
 rtl/edulent_sync_fifo.sv | 46 ++++
 rtl/edulent_out_uart.sv | 131 +++++++++++++
 tb/tb_edulent_out_uart.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/edulent_pkg.sv
// Shared types and constants for the edulent CPU output UART.
package edulent_pkg;
  localparam int unsigned DATA_W = 8;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } tx_state_t;
endpackage

// File: rtl/edulent_sync_fifo.sv
// Synchronous FIFO with wrap-around pointers; a pop frees room for a same-cycle push.
module edulent_sync_fifo
  import edulent_pkg::*;
#(
  parameter int unsigned WIDTH = DATA_W,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout    = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr[AW-1:0]] <= din;
        wr_ptr              <= wr_ptr + PTR_ONE;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + PTR_ONE;
      end
    end
  end
endmodule

// File: rtl/edulent_out_uart.sv
// Captures changes of the CPU output port into a FIFO and serialises them as 8N1 UART frames.
module edulent_out_uart
  import edulent_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 868,
  parameter int unsigned FIFO_DEPTH   = 4
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic [DATA_W-1:0] i_data,
  output logic              o_tx,
  output logic              o_busy,
  output logic              o_overflow
);
  localparam logic [15:0] BAUD_LAST = 16'(CLKS_PER_BIT - 1);

  tx_state_t         state;
  logic [DATA_W-1:0] prev;
  logic [DATA_W-1:0] shreg;
  logic [DATA_W-1:0] fifo_dout;
  logic [15:0]       baud_cnt;
  logic [2:0]        bit_idx;
  logic              tx_q;
  logic              busy_q;
  logic              ovf_q;
  logic              capture;
  logic              pop;
  logic              full;
  logic              empty;
  logic              baud_done;

  assign baud_done = (baud_cnt == BAUD_LAST);
  assign capture   = !i_rst && (i_data != prev);
  // Pop from IDLE, or at the last STOP cycle so back-to-back frames have no gap.
  assign pop       = !i_rst && !empty &&
                     ((state == IDLE) || ((state == STOP) && baud_done));

  edulent_sync_fifo #(
    .WIDTH(DATA_W),
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk  (i_clk),
    .rst  (i_rst),
    .push (capture),
    .pop  (pop),
    .din  (i_data),
    .dout (fifo_dout),
    .full (full),
    .empty(empty)
  );

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state    <= IDLE;
      tx_q     <= 1'b1;
      busy_q   <= 1'b0;
      ovf_q    <= 1'b0;
      prev     <= '0;
      shreg    <= '0;
      baud_cnt <= '0;
      bit_idx  <= '0;
    end else begin
      if (capture) begin
        prev <= i_data;
        if (full && !pop) ovf_q <= 1'b1;
      end

      case (state)
        IDLE: begin
          if (pop) begin
            shreg    <= fifo_dout;
            state    <= START;
            tx_q     <= 1'b0;
            busy_q   <= 1'b1;
            baud_cnt <= '0;
          end
        end
        START: begin
          if (baud_done) begin
            baud_cnt <= '0;
            bit_idx  <= '0;
            state    <= DATA;
            tx_q     <= shreg[0];
            shreg    <= shreg >> 1;
          end else begin
            baud_cnt <= baud_cnt + 16'd1;
          end
        end
        DATA: begin
          if (baud_done) begin
            baud_cnt <= '0;
            if (bit_idx == 3'd7) begin
              state <= STOP;
              tx_q  <= 1'b1;
            end else begin
              bit_idx <= bit_idx + 3'd1;
              tx_q    <= shreg[0];
              shreg   <= shreg >> 1;
            end
          end else begin
            baud_cnt <= baud_cnt + 16'd1;
          end
        end
        STOP: begin
          if (baud_done) begin
            baud_cnt <= '0;
            if (pop) begin
              shreg <= fifo_dout;
              state <= START;
              tx_q  <= 1'b0;
            end else begin
              state  <= IDLE;
              busy_q <= 1'b0;
            end
          end else begin
            baud_cnt <= baud_cnt + 16'd1;
          end
        end
        default: begin
          state  <= IDLE;
          tx_q   <= 1'b1;
          busy_q <= 1'b0;
        end
      endcase
    end
  end

  assign o_tx       = tx_q;
  assign o_busy     = busy_q;
  assign o_overflow = ovf_q;
endmodule

// File: tb/tb_edulent_out_uart.sv
// Self-checking bench: table vectors, hand-written corner sequences and a UART frame scoreboard.
module tb_edulent_out_uart;
  localparam int unsigned CPB = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] din;
  logic       tx;
  logic       busy;
  logic       ovf;

  int unsigned chk_cnt  = 0;
  int unsigned pass_cnt = 0;
  logic [7:0]  sb[$];

  typedef struct {
    logic [7:0] din;
    bit         exp_frame;
    logic [7:0] exp_byte;
    logic       exp_ovf;
  } vec_t;
  vec_t vecs[8];

  edulent_out_uart #(
    .CLKS_PER_BIT(CPB),
    .FIFO_DEPTH  (4)
  ) dut (
    .i_clk     (clk),
    .i_rst     (rst),
    .i_data    (din),
    .o_tx      (tx),
    .o_busy    (busy),
    .o_overflow(ovf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    chk_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic tick(input int unsigned n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    din = 8'h00;
    rst = 1'b1;
    tick(2);
    rst = 1'b0;
  endtask

  // Frame decoder: samples mid-bit, compares each received byte against the queue.
  bit          mon_active = 1'b0;
  int unsigned mon_cnt    = 0;
  logic [7:0]  mon_bits   = 8'h00;
  initial begin : monitor
    int k;
    forever begin
      @(negedge clk);
      if (rst === 1'b1) begin
        mon_active = 1'b0;
      end else if (!mon_active) begin
        if (tx === 1'b0) begin
          mon_active = 1'b1;
          mon_cnt    = 0;
        end
      end else begin
        mon_cnt++;
        if (mon_cnt % CPB == CPB / 2) begin
          k = int'(mon_cnt / CPB);
          if (k == 0) begin
            chk("start_bit", 32'(tx), 32'd0);
          end else if (k <= 8) begin
            mon_bits[k-1] = tx;
          end else begin
            chk("stop_bit", 32'(tx), 32'd1);
            chk("frame_expected", 32'(sb.size() != 0), 32'd1);
            if (sb.size() != 0) chk("frame_data", 32'(mon_bits), 32'(sb.pop_front()));
            mon_active = 1'b0;
          end
        end
      end
    end
  end

  initial begin : main
    int unsigned bad;
    int unsigned busy_cnt;
    int          first_low;
    logic [7:0]  a5;
    logic        exp_tx;

    vecs[0] = '{8'hA5, 1'b1, 8'hA5, 1'b0};
    vecs[1] = '{8'hA5, 1'b0, 8'h00, 1'b0};
    vecs[2] = '{8'h3C, 1'b1, 8'h3C, 1'b0};
    vecs[3] = '{8'h00, 1'b1, 8'h00, 1'b0};
    vecs[4] = '{8'hFF, 1'b1, 8'hFF, 1'b0};
    vecs[5] = '{8'hFF, 1'b0, 8'h00, 1'b0};
    vecs[6] = '{8'h80, 1'b1, 8'h80, 1'b0};
    vecs[7] = '{8'h01, 1'b1, 8'h01, 1'b0};

    rst = 1'b1;
    din = 8'h00;
    tick(3);
    chk("reset_tx", 32'(tx), 32'd1);
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_ovf", 32'(ovf), 32'd0);
    rst = 1'b0;

    // Single 0xA5 frame, cycle-exact waveform and latency.
    a5  = 8'hA5;
    din = 8'hA5;
    sb.push_back(8'hA5);
    tick(1);
    chk("latency_tx_still_high", 32'(tx), 32'd1);
    tick(1);
    for (int c = 0; c < 40; c++) begin
      if (c < 4) exp_tx = 1'b0;
      else if (c < 36) exp_tx = a5[(c-4)/4];
      else exp_tx = 1'b1;
      chk("a5_tx", 32'(tx), 32'(exp_tx));
      chk("a5_busy", 32'(busy), 32'd1);
      tick(1);
    end
    chk("a5_busy_end", 32'(busy), 32'd0);
    chk("a5_tx_end", 32'(tx), 32'd1);
    tick(5);

    // Constant zero produces no traffic.
    do_reset();
    bad = 0;
    for (int c = 0; c < 100; c++) begin
      if (tx !== 1'b1 || busy !== 1'b0) bad++;
      tick(1);
    end
    chk("const_zero_quiet", bad, 0);

    // Table vectors.
    do_reset();
    for (int i = 0; i < 8; i++) begin
      din = vecs[i].din;
      if (vecs[i].exp_frame) sb.push_back(vecs[i].exp_byte);
      tick(50);
      chk("vec_busy_idle", 32'(busy), 32'd0);
      chk("vec_ovf", 32'(ovf), 32'(vecs[i].exp_ovf));
      chk("vec_sb_drained", sb.size(), 0);
    end

    // Three back-to-back frames with no idle gap.
    do_reset();
    din = 8'h01; sb.push_back(8'h01); tick(1);
    din = 8'h02; sb.push_back(8'h02); tick(1);
    din = 8'h03; sb.push_back(8'h03);
    busy_cnt  = 0;
    first_low = -1;
    for (int c = 0; c < 130; c++) begin
      if (busy === 1'b1) busy_cnt++;
      else if (first_low < 0) first_low = c;
      tick(1);
    end
    chk("b2b_busy_cycles", busy_cnt, 120);
    chk("b2b_first_idle", 32'(first_low), 32'd120);
    chk("b2b_sb_drained", sb.size(), 0);

    // Overflow: one in flight, four queued, sixth dropped.
    do_reset();
    for (int i = 0; i < 6; i++) begin
      din = 8'h11 + 8'(i);
      if (i < 5) sb.push_back(8'h11 + 8'(i));
      tick(1);
    end
    chk("ovf_set", 32'(ovf), 32'd1);
    tick(220);
    chk("ovf_sticky", 32'(ovf), 32'd1);
    chk("ovf_busy_idle", 32'(busy), 32'd0);
    chk("ovf_sb_drained", sb.size(), 0);
    do_reset();
    chk("ovf_cleared", 32'(ovf), 32'd0);

    // Reset pulse mid-DATA aborts the frame.
    din = 8'h55;
    tick(16);
    chk("abort_busy_before", 32'(busy), 32'd1);
    rst = 1'b1;
    din = 8'h00;
    tick(1);
    chk("abort_tx_high", 32'(tx), 32'd1);
    chk("abort_busy_low", 32'(busy), 32'd0);
    rst = 1'b0;
    bad = 0;
    for (int c = 0; c < 60; c++) begin
      if (busy !== 1'b0 || tx !== 1'b1) bad++;
      tick(1);
    end
    chk("abort_no_frames", bad, 0);

    // Full FIFO: STOP-to-START pop coincides with a new push.
    do_reset();
    din = 8'h21; sb.push_back(8'h21);
    for (int i = 1; i < 5; i++) begin
      tick(1);
      din = 8'h21 + 8'(i);
      sb.push_back(8'h21 + 8'(i));
    end
    tick(1);
    chk("full_no_ovf_yet", 32'(ovf), 32'd0);
    tick(36);
    din = 8'h26;
    sb.push_back(8'h26);
    tick(1);
    chk("full_pop_push_no_ovf", 32'(ovf), 32'd0);
    tick(240);
    chk("full_pop_push_ovf_final", 32'(ovf), 32'd0);
    chk("full_pop_push_idle", 32'(busy), 32'd0);
    chk("full_pop_push_sb_drained", sb.size(), 0);

    tick(20);
    chk("final_sb_empty", sb.size(), 0);
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end
endmodule
